seq_mac_unit: RTL
=================

SEQ_MAC_UNIT -- requirements
Module: seq_mac_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits (4..16).
REQ-002 SHALL provide parameter ACC_W, default 20, accumulator width in bits (>= 2*WIDTH).
REQ-003 SHALL provide clk_i  input  1  clock; all state updates on posedge.
REQ-004 SHALL provide nreset_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide start_i  input  1  request one multiply-accumulate of a_i*b_i.
REQ-006 SHALL provide clear_i  input  1  zero the accumulator and overflow flag.
REQ-007 SHALL provide a_i  input  WIDTH  unsigned multiplicand, sampled with start_i.
REQ-008 SHALL provide b_i  input  WIDTH  unsigned multiplier, sampled with start_i.
REQ-009 SHALL provide acc_o  output  ACC_W  accumulator value, registered.
REQ-010 SHALL provide busy_o  output  1  high in states MUL and ACC.
REQ-011 SHALL provide done_o  output  1  one-cycle pulse, high in state DONE.
REQ-012 SHALL provide ovf_o  output  1  sticky accumulator-overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, ACC, DONE; all outputs registered or decoded from state only.
REQ-014 IDLE or DONE with start_i=1 at edge 0 SHALL latch a_i, b_i, zero the partial product and bit counter, and enter MUL.
REQ-015 MUL SHALL perform one shift-add step per cycle (add shifted a if current b bit is 1), exiting to ACC after exactly WIDTH steps (edge WIDTH).
REQ-016 ACC SHALL add the 2*WIDTH-bit product, zero-extended, to acc at edge WIDTH+1, then enter DONE.
REQ-017 DONE SHALL last exactly one cycle; done_o=1 and acc_o holds the new sum in that cycle; next state IDLE, or MUL if start_i=1.
REQ-018 Total latency SHALL be WIDTH+2 edges from start acceptance to done_o high; back-to-back throughput one op per WIDTH+2 cycles.
REQ-019 start_i while in MUL or ACC SHALL be ignored, with no queuing.
REQ-020 Accumulation SHALL wrap modulo 2^ACC_W; a carry out of bit ACC_W-1 SHALL set ovf_o, which stays set until clear_i or reset.
REQ-021 clear_i in IDLE or DONE SHALL zero acc_o and ovf_o at the next edge; clear_i in MUL or ACC SHALL be ignored.
REQ-022 clear_i and start_i together in IDLE/DONE SHALL zero acc and ovf and start the operation, so the result equals the product alone.
REQ-023 Operand zero (a_i=0 or b_i=0) SHALL still take full latency and leave acc unchanged.

Reset
REQ-024 nreset_i low SHALL immediately force state IDLE, acc_o=0, ovf_o=0, busy_o=0, done_o=0, counter and operand registers 0.
REQ-025 Reset asserted mid-operation SHALL abort it without a done_o pulse; after release, the block SHALL accept start_i at the first edge.

Structure
REQ-026 Shared package mac_pkg SHALL hold the state encoding (IDLE=0, MUL=1, ACC=2, DONE=3) and default WIDTH/ACC_W constants.
REQ-027 Shift-add datapath (operand regs, partial product, bit counter) SHALL be sub-module seq_mul_core; FSM and accumulator remain in seq_mac_unit.

Verification (WIDTH=8, ACC_W=20)
REQ-028 Reset, start with a=3, b=5 -> busy_o high edges 1..9, done_o high cycle after edge 9 only, acc_o=15, ovf_o=0.
REQ-029 Without clear, start a=10, b=20 after the previous operation -> acc_o=215; start pulsed at edge 4 of the op -> ignored, single done_o.
REQ-030 Seventeen back-to-back ops, a=b=255 -> after 16 ops acc_o=1040400, ovf_o=0; after 17th acc_o=56849, ovf_o=1, done_o every 10 cycles.
REQ-031 clear_i+start_i together, a=7, b=9, with acc=56849 and ovf=1 -> acc_o=63, ovf_o=0; clear_i alone during MUL -> no effect.
REQ-032 nreset_i pulsed low during edge 5 of MUL -> outputs zero at once, no done_o; start a=2, b=2 right after release -> acc_o=4.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the sequential multiply-accumulate unit.
package mac_pkg;

   // Default operand and accumulator widths.
   localparam int DEF_WIDTH = 8;
   localparam int DEF_ACC_W = 20;

   // Controller state encoding.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ACC  = 2'd2,
      S_DONE = 2'd3
   } mac_state_e;

endpackage : mac_pkg

// File: rtl/seq_mul_core.sv
// Shift-add multiplier datapath: operand registers, partial product and
// bit counter. One multiplier bit is consumed per step; the controller
// decides when to load and when to step.
module seq_mul_core
   import mac_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk_i,
   input  logic                 nreset_i,
   input  logic                 load_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic [2*WIDTH-1:0]   prod_o,
   output logic                 last_o
);

   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [PW-1:0]    pp_q, pp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] b_sh;
   logic [PW-1:0]    a_sh;

   // Current multiplier bit and multiplicand aligned to that bit position.
   assign b_sh = b_q >> cnt_q;
   assign a_sh = {{WIDTH{1'b0}}, a_q} << cnt_q;

   // Next-state for operands, partial product and counter.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      pp_d  = pp_q;
      cnt_d = cnt_q;
      if (load_i) begin
         a_d   = a_i;
         b_d   = b_i;
         pp_d  = '0;
         cnt_d = '0;
      end else if (step_i) begin
         if (b_sh[0]) pp_d = pp_q + a_sh;
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Datapath registers, cleared asynchronously.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         a_q   <= '0;
         b_q   <= '0;
         pp_q  <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         pp_q  <= pp_d;
         cnt_q <= cnt_d;
      end
   end

   assign prod_o = pp_q;
   // The step taken while this is high consumes the top multiplier bit.
   assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule : seq_mul_core

// File: rtl/seq_mac_unit.sv
// Sequential multiply-accumulate: controller FSM and wrapping accumulator
// around a shift-add multiplier core. One op every WIDTH+2 cycles.
module seq_mac_unit
   import mac_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic              clk_i,
   input  logic              nreset_i,
   input  logic              start_i,
   input  logic              clear_i,
   input  logic [WIDTH-1:0]  a_i,
   input  logic [WIDTH-1:0]  b_i,
   output logic [ACC_W-1:0]  acc_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovf_o
);

   mac_state_e         state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               ovf_q, ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               load;
   logic               last;
   logic [2*WIDTH-1:0] prod;
   logic [ACC_W:0]     sum;

   seq_mul_core #(.WIDTH(WIDTH)) u_core (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .load_i   (load),
      .step_i   (state_q == S_MUL),
      .a_i      (a_i),
      .b_i      (b_i),
      .prod_o   (prod),
      .last_o   (last)
   );

   // Extra top bit of the sum is the carry that raises the sticky overflow.
   assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - 2*WIDTH){1'b0}}, prod};

   // Next state, accumulator update and output decode. Clear and start are
   // only honoured between operations; clear is applied before the new op
   // accumulates, so clear+start yields the product alone.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (clear_i) begin
               acc_d = '0;
               ovf_d = 1'b0;
            end
            if (start_i) begin
               load    = 1'b1;
               state_d = S_MUL;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL: if (last) state_d = S_ACC;
         S_ACC: begin
            acc_d   = sum[ACC_W-1:0];
            if (sum[ACC_W]) ovf_d = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_MUL) || (state_d == S_ACC);
      done_d = (state_d == S_DONE);
   end

   // Controller state, accumulator and registered status outputs.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign acc_o  = acc_q;
   assign ovf_o  = ovf_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule : seq_mac_unit
